// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and fetch sequencer for the instruction ROM (instrMem).
// Walks the ROM one word at a time, takes branch/jump redirects from execute
// (followed by a one-cycle bubble), and stops for good at the last word.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   start          one-cycle pulse that leaves IDLE and starts fetching
//   stall          downstream not ready; hold the current address (RUN only)
//   redirectValid  taken branch/jump this cycle
//   redirectAdrs   redirect target byte address (low two bits are dropped)
//   readAdrs       byte address driven to instrMem
//   fetchValid     instrMem output is a real instruction this cycle
//   halted         fetch ended at LAST_PC; sticky until reset
//   misalignErr    sticky; some redirect target was not word aligned
//   fetchCount     accepted fetches, saturating
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter int                ADDR_W   = 7,
    parameter logic [ADDR_W-1:0] RESET_PC = 7'h00,
    parameter logic [ADDR_W-1:0] LAST_PC  = 7'h7C,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stall,
    input  logic              redirectValid,
    input  logic [ADDR_W-1:0] redirectAdrs,
    output logic [ADDR_W-1:0] readAdrs,
    output logic              fetchValid,
    output logic              halted,
    output logic              misalignErr,
    output logic [CNT_W-1:0]  fetchCount
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [ADDR_W-1:0]   w_pc_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_mis;
    logic                w_mis_nxt;
    logic                r_fetch_valid;
    logic                w_fetch_valid_nxt;
    logic                r_halted;
    logic                w_halted_nxt;

    logic                w_take_redirect;
    logic                w_accept;
    logic                w_at_last;
    logic [ADDR_W-1:0]   w_redirect_aligned;

    // Redirects count in RUN and FLUSH only; a fetch is accepted in RUN when
    // neither a redirect squashes it nor stall holds it.
    assign w_take_redirect    = redirectValid && ((r_state == ST_RUN) || (r_state == ST_FLUSH));
    assign w_accept           = (r_state == ST_RUN) && !redirectValid && !stall;
    assign w_at_last          = (r_pc == LAST_PC);
    assign w_redirect_aligned = {redirectAdrs[ADDR_W-1:2], 2'b00};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; redirect beats stall and the halt condition.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (redirectValid) begin
                    w_state_nxt = ST_FLUSH;
                end else if (stall) begin
                    w_state_nxt = ST_RUN;
                end else if (w_at_last) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_FLUSH: begin
                // A back-to-back redirect restarts the bubble.
                if (redirectValid) begin
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the status flags come out of flops
    // aligned with the state they describe.
    always_comb begin
        w_fetch_valid_nxt = 1'b0;
        w_halted_nxt      = 1'b0;
        case (w_state_nxt)
            ST_RUN:  w_fetch_valid_nxt = 1'b1;
            ST_HALT: w_halted_nxt      = 1'b1;
            default: begin
                w_fetch_valid_nxt = 1'b0;
                w_halted_nxt      = 1'b0;
            end
        endcase
    end

    // Address, counter and error-flag next values.
    always_comb begin
        w_pc_nxt  = r_pc;
        w_cnt_nxt = r_cnt;
        w_mis_nxt = r_mis;
        if (w_take_redirect) begin
            w_pc_nxt  = w_redirect_aligned;
            w_mis_nxt = r_mis | (redirectAdrs[1:0] != 2'b00);
        end else if (w_accept) begin
            // The last word is held, never wrapped.
            if (w_at_last) begin
                w_pc_nxt = r_pc;
            end else begin
                w_pc_nxt = r_pc + ADDR_W'(4);
            end
            if (r_cnt != CNT_MAX) begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end else begin
                w_cnt_nxt = r_cnt;
            end
        end else begin
            w_pc_nxt  = r_pc;
            w_cnt_nxt = r_cnt;
        end
    end

    // Datapath and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_cnt         <= {CNT_W{1'b0}};
            r_mis         <= 1'b0;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_cnt         <= w_cnt_nxt;
            r_mis         <= w_mis_nxt;
            r_fetch_valid <= w_fetch_valid_nxt;
            r_halted      <= w_halted_nxt;
        end
    end

    assign readAdrs    = r_pc;
    assign fetchValid  = r_fetch_valid;
    assign halted      = r_halted;
    assign misalignErr = r_mis;
    assign fetchCount  = r_cnt;

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program-counter and fetch-sequencing stage directly upstream of the instruction memory (instrMem). It owns the 7-bit byte address `readAdrs` that drives the ROM.
- Advances sequentially by one word (4 bytes) per accepted fetch.
- Accepts branch/jump redirects from the execute stage and inserts a one-cycle bubble after each redirect.
- Halts cleanly at the end of the 32-word address space.
- Tells the downstream decode/register-read stage when the decoded fields (rd/rs1/rs2/imm) are valid.

Parameters:
ADDR_W, 7, byte-address width; matches the instrMem `readAdrs` port.
RESET_PC, 7'h00, address loaded on reset; must be word-aligned.
LAST_PC, 7'h7C, address of the last word; reaching it ends sequential fetch.
CNT_W, 8, width of the fetch counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; leaves IDLE and begins fetching.
stall  input  1  downstream not ready; hold the current address.
redirectValid  input  1  branch/jump taken this cycle.
redirectAdrs  input  ADDR_W  redirect target byte address.
readAdrs  output  ADDR_W  byte address to instrMem.
fetchValid  output  1  instrMem outputs are a real instruction this cycle.
halted  output  1  fetch ended at LAST_PC; sticky until reset.
misalignErr  output  1  sticky; a redirect target had bits [1:0] != 0.
fetchCount  output  CNT_W  number of accepted fetches, saturating.

Behaviour:
- Reset (asynchronous, rst_n=0), all registered:
  - readAdrs=RESET_PC, state=IDLE.
  - fetchValid=0, halted=0, misalignErr=0, fetchCount=0.
  - Reset asserted mid-operation aborts immediately to these values; no partial updates.
- States: IDLE, RUN, FLUSH, HALT. fetchValid=1 only in RUN. halted=1 only in HALT.
- IDLE:
  - start=1 -> RUN at the next edge; readAdrs is unchanged.
  - redirectValid and stall are ignored.
- RUN, evaluated in this priority order each edge:
  1. redirectValid=1:
     - readAdrs <= {redirectAdrs[6:2],2'b00} -> FLUSH.
     - If redirectAdrs[1:0]!=0, set misalignErr.
     - The current fetch is squashed and not counted.
     - Redirect wins over stall and over the halt condition.
  2. stall=1: hold readAdrs and fetchCount; stay in RUN.
  3. readAdrs==LAST_PC:
     - Fetch is accepted; fetchCount increments.
     - -> HALT; readAdrs is held at LAST_PC (no wrap to 0).
  4. Otherwise:
     - readAdrs <= readAdrs+4, modulo 2^ADDR_W (wrap is unreachable because of step 3).
     - fetchCount increments.
- fetchCount: increments by 1 per accepted fetch; saturates at 2^CNT_W-1 and never wraps.
- FLUSH (bubble; instrMem output at the new address is not yet trusted):
  - fetchValid=0 for exactly one cycle, then -> RUN.
  - redirectValid=1 in FLUSH: take the new target (same alignment and misalignErr rules) and stay in FLUSH one more cycle.
  - stall is ignored in FLUSH.
- HALT:
  - Terminal; only reset exits.
  - start, redirectValid and stall are ignored.
  - readAdrs stays at LAST_PC; fetchValid=0.
- start while in RUN, FLUSH or HALT: ignored.
- Latency:
  - readAdrs changes one edge after the controlling input is sampled.
  - instrMem is combinational, so decoded fields are valid in the same cycle as fetchValid.
- Simultaneous redirectValid and stall in RUN: redirect taken; stall has no effect.
- RESET_PC and LAST_PC must be word-aligned; the low two bits of readAdrs are always 0.

Test Plan:
- Reset then start pulse at cycle 2:
  - fetchValid rises at cycle 3.
  - readAdrs sequence 0x00,0x04,0x08,0x0C on successive cycles.
  - fetchCount reaches 4 after 4 accepted fetches.
- Stall held 3 cycles at readAdrs=0x10: readAdrs stays 0x10, fetchValid stays 1, fetchCount is unchanged; on release, next readAdrs=0x14.
- Redirect to 0x1C while at 0x48 (stall=1 in the same cycle):
  - Next cycle readAdrs=0x1C with fetchValid=0 (FLUSH).
  - Following cycle fetchValid=1 and readAdrs=0x1C.
  - The squashed fetch is not counted.
- Redirect to 0x22: readAdrs becomes 0x20, misalignErr=1 and stays 1 through later fetches until rst_n=0.
- Run from 0x00 with no stalls:
  - After the fetch at 0x7C: halted=1, fetchValid=0, readAdrs=0x7C, fetchCount=32.
  - A later redirect to 0x00 and a start pulse are both ignored.
- rst_n pulsed low mid-RUN at readAdrs=0x30 (asynchronous, between edges): all outputs return immediately to reset values; the unit waits in IDLE for start.
